drone_top: RTL and testbench
============================

# drone_top

Flight-control core of the quad-rotor drone model. It turns an altitude command and a direction command into a per-motor RPM target for 4 motors. A closed loop then drives each motor setpoint toward its target using the sensed motor RPM. It sits between the command interface and the four motor feedback models, which close the loop by returning `rpm_sense`.

## Interface
- `RPM_W`, 8: width of RPM values.
- `HOVER_RPM`, 128: base target for altcmd HOLD.
- `ALT_DELTA`, 32: added or subtracted from the base for CLIMB/DESCEND.
- `DIR_DELTA`, 16: per-motor offset applied for direction commands.
- `GAIN_SHIFT`, 2: loop gain; `delta = error >>> GAIN_SHIFT`.
- `MAX_SLEW`, 8: per-update step limit, used only with the slew option.
- `clk`  in  1: sole clock; all logic on the rising edge.
- `resetn`  in  1: reset is synchronous and active-high (port keeps the codebase name `resetn`; asserted = 1).
- `altcmd`  in  2: 00 HOLD, 01 CLIMB, 10 DESCEND, 11 LAND.
- `dircmd`  in  3: 000 NONE, 001 FWD, 010 BACK, 011 LEFT, 100 RIGHT, 101 YAW_CW, 110 YAW_CCW, 111 NONE.
- `rpm_sense`  in  [4][RPM_W]: measured RPM per motor.
- `mot_set`  out  [4][RPM_W]: RPM setpoint per motor, registered.

## Operation
- Motor map (X frame): 0 front-left, 1 front-right, 2 rear-right, 3 rear-left. Motors 0 and 2 spin CW; motors 1 and 3 spin CCW.
- Base target:
  - HOLD = HOVER_RPM.
  - CLIMB = HOVER_RPM + ALT_DELTA.
  - DESCEND = HOVER_RPM − ALT_DELTA.
  - LAND = 0 for all motors; dircmd is ignored.
- Direction offsets, +D / −D with D = DIR_DELTA:
  - FWD: rear (2,3) +D, front (0,1) −D.
  - BACK: the reverse of FWD.
  - LEFT: right (1,2) +D, left (0,3) −D.
  - RIGHT: the reverse of LEFT.
  - YAW_CW: CCW motors (1,3) +D, CW motors (0,2) −D.
  - YAW_CCW: the reverse of YAW_CW.
  - NONE: 0.
- Target arithmetic is signed, RPM_W+2 bits wide, and saturates to the range [0, 2^RPM_W−1].
- Per motor, each cycle:
  - `error = target − rpm_sense_q`, signed, RPM_W+1 bits.
  - `delta = error >>> GAIN_SHIFT`.
  - If error ≠ 0 and delta = 0, delta = sign(error) (±1), so the loop reaches zero steady-state error.
  - If error = 0, delta = 0.
- Setpoint update: `mot_set <= sat(mot_set + delta)`, saturating to the range [0, 2^RPM_W−1]. It never wraps.
- The four motor channels are independent; one channel saturating does not affect the others.

## Timing
- Reset (`resetn` = 1 at a rising edge):
  - All `mot_set` outputs = 0.
  - Registered commands = HOLD/NONE.
  - Registered sense values = 0.
  - Reset takes effect mid-operation on the next edge and overrides any update.
- Stage 1: `altcmd`, `dircmd` and `rpm_sense` are registered at edge k.
- Stage 2: `mot_set` is updated at edge k+1 from the stage-1 values.
  - Input-to-output latency is 2 cycles.
  - One update is made per cycle.
- A command change takes effect two edges later. There is no handshake; commands are level-sensitive.
- In the first cycle after reset deasserts, the stage-1 registers still hold their reset values. `mot_set` therefore first moves on the second edge after deassertion.

## Configuration
- `DRONE_TOP_SLEW_LIMIT_EN` defined:
  - delta is clamped to [−MAX_SLEW, +MAX_SLEW] after the gain shift and the ±1 rule.
  - The clamp is applied before the add.
- Not defined: there is no clamp, and delta is used as computed.

## Structure
- Package `drone_pkg` holds:
  - `altcmd_e` and `dircmd_e` enums.
  - `NUM_MOTORS` = 4.
  - Motor index constants (FL, FR, RR, RL).
  - The per-command direction-sign lookup function.
- Sub-module `motor_ctrl` handles one motor: error, gain, ±1 rule, optional slew clamp and the saturating setpoint register. The top instantiates it 4 times, and computes the targets and the input registers itself.

## Test plan
Defaults are used unless noted. The bench echoes `rpm_sense = mot_set` unless noted.
- Reset: hold `resetn` = 1 for 2 cycles with arbitrary inputs → all `mot_set` = 0; after release, the first change appears 2 edges later.
- HOLD/NONE, `rpm_sense` held at 0 → each `mot_set` steps 0→32→64…; with `DRONE_TOP_SLEW_LIMIT_EN`, it steps 0→8→16….
- CLIMB/FWD, echo loop → motors 0 and 1 converge to exactly 144 and motors 2 and 3 to exactly 176; residual error ≤ 3 closes via ±1 steps.
- YAW_CW from settled HOLD (all 128) → motors 1 and 3 converge to 144 and motors 0 and 2 to 112; with any dircmd, LAND → all motors decay to 0 and never go below 0.
- Saturation: HOVER_RPM = 240, CLIMB/BACK → front targets clamp to 255 and `mot_set` stops at 255 without wrapping; separately, `rpm_sense` = 255 with target 0 gives a negative delta, and the result floors at 0.
- Latency: toggle `dircmd` NONE→LEFT for a single cycle → `mot_set` reacts exactly 2 edges later, for exactly one update.

Source files
------------

// File: rtl/drone_pkg.sv
// drone_pkg: shared command encodings, motor indices and the direction-sign
// lookup used by the drone flight-control core.
package drone_pkg;

  localparam int NUM_MOTORS = 4;

  // X-frame motor map; FL and RR spin CW, FR and RL spin CCW.
  localparam logic [1:0] MOT_FL = 2'd0;
  localparam logic [1:0] MOT_FR = 2'd1;
  localparam logic [1:0] MOT_RR = 2'd2;
  localparam logic [1:0] MOT_RL = 2'd3;

  localparam logic signed [1:0] SGN_POS  = 2'sb01;
  localparam logic signed [1:0] SGN_NEG  = 2'sb11;
  localparam logic signed [1:0] SGN_ZERO = 2'sb00;

  typedef enum logic [1:0] {
    ALT_HOLD    = 2'b00,
    ALT_CLIMB   = 2'b01,
    ALT_DESCEND = 2'b10,
    ALT_LAND    = 2'b11
  } altcmd_e;

  typedef enum logic [2:0] {
    DIR_NONE     = 3'b000,
    DIR_FWD      = 3'b001,
    DIR_BACK     = 3'b010,
    DIR_LEFT     = 3'b011,
    DIR_RIGHT    = 3'b100,
    DIR_YAW_CW   = 3'b101,
    DIR_YAW_CCW  = 3'b110,
    DIR_NONE_ALT = 3'b111
  } dircmd_e;

  // Sign of the direction offset a command applies to one motor (+1, -1 or 0).
  function automatic logic signed [1:0] dir_sign(input dircmd_e dir, input logic [1:0] motor);
    logic pos;
    logic act;
    pos = 1'b0;
    act = 1'b1;
    case (dir)
      DIR_FWD:     pos = (motor == MOT_RR) || (motor == MOT_RL);
      DIR_BACK:    pos = (motor == MOT_FL) || (motor == MOT_FR);
      DIR_LEFT:    pos = (motor == MOT_FR) || (motor == MOT_RR);
      DIR_RIGHT:   pos = (motor == MOT_FL) || (motor == MOT_RL);
      DIR_YAW_CW:  pos = (motor == MOT_FR) || (motor == MOT_RL);
      DIR_YAW_CCW: pos = (motor == MOT_FL) || (motor == MOT_RR);
      default:     act = 1'b0;
    endcase
    if (!act) return SGN_ZERO;
    return pos ? SGN_POS : SGN_NEG;
  endfunction

endpackage

// File: rtl/drone_top_motor_ctrl.sv
// motor_ctrl: one motor's proportional loop. Error against the registered
// sense value, gain shift, +/-1 nudge for small errors, optional step clamp
// and a saturating setpoint register.
// Optional feature macro: DRONE_TOP_SLEW_LIMIT_EN clamps each update step
// to +/-MAX_SLEW before it is added.
module motor_ctrl #(
  parameter int RPM_W      = 8,
  parameter int GAIN_SHIFT = 2,
  parameter int MAX_SLEW   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [RPM_W-1:0] target,
  input  logic [RPM_W-1:0] sense,
  output logic [RPM_W-1:0] mot_set
);

  localparam int ERR_W = RPM_W + 1;
  localparam int SUM_W = RPM_W + 2;

`ifdef DRONE_TOP_SLEW_LIMIT_EN
  localparam bit SLEW_EN = 1'b1;
`else
  localparam bit SLEW_EN = 1'b0;
`endif

  localparam logic signed [ERR_W-1:0] ONE_POS  = ERR_W'(1);
  localparam logic signed [ERR_W-1:0] ONE_NEG  = {ERR_W{1'b1}};
  localparam logic signed [ERR_W-1:0] SLEW_POS = ERR_W'(MAX_SLEW);
  localparam logic signed [ERR_W-1:0] SLEW_NEG = -SLEW_POS;
  localparam logic [RPM_W-1:0]        RPM_MAX  = '1;

  logic signed [ERR_W-1:0] err_p0;
  logic signed [ERR_W-1:0] shift_p0;
  logic signed [ERR_W-1:0] step_p0;
  logic signed [ERR_W-1:0] delta_p0;
  logic signed [SUM_W-1:0] sum_p0;
  logic [RPM_W-1:0]        set_p1;

  function automatic logic signed [ERR_W-1:0] clamp_slew(input logic signed [ERR_W-1:0] d);
    if (d > SLEW_POS) return SLEW_POS;
    else if (d < SLEW_NEG) return SLEW_NEG;
    else return d;
  endfunction

  function automatic logic [RPM_W-1:0] sat_rpm(input logic signed [SUM_W-1:0] v);
    if (v[SUM_W-1]) return '0;
    else if (|v[SUM_W-2:RPM_W]) return RPM_MAX;
    else return v[RPM_W-1:0];
  endfunction

  // Error, gain, small-error nudge, optional clamp and the widened sum.
  always_comb begin
    err_p0   = $signed({1'b0, target}) - $signed({1'b0, sense});
    shift_p0 = err_p0 >>> GAIN_SHIFT;
    step_p0  = shift_p0;
    if ((err_p0 != '0) && (shift_p0 == '0)) begin
      step_p0 = err_p0[ERR_W-1] ? ONE_NEG : ONE_POS;
    end
    delta_p0 = SLEW_EN ? clamp_slew(step_p0) : step_p0;
    sum_p0   = $signed({2'b00, set_p1}) + $signed({{(SUM_W-ERR_W){delta_p0[ERR_W-1]}}, delta_p0});
  end

  // ---- stage boundary: setpoint register ----
  // Saturating setpoint update; held while the input stage is not yet valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      set_p1 <= '0;
    end else if (en) begin
      set_p1 <= sat_rpm(sum_p0);
    end
  end

  assign mot_set = set_p1;

endmodule

// File: rtl/drone_top.sv
// drone_top: flight-control core. Registers the altitude/direction commands
// and the sensed RPMs, forms a saturated per-motor target and drives four
// independent motor_ctrl loops toward it.
// Optional feature macro: DRONE_TOP_SLEW_LIMIT_EN (step clamp inside motor_ctrl).
module drone_top
  import drone_pkg::*;
#(
  parameter int RPM_W      = 8,
  parameter int HOVER_RPM  = 128,
  parameter int ALT_DELTA  = 32,
  parameter int DIR_DELTA  = 16,
  parameter int GAIN_SHIFT = 2,
  parameter int MAX_SLEW   = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [1:0]       altcmd,
  input  logic [2:0]       dircmd,
  input  logic [RPM_W-1:0] rpm_sense [NUM_MOTORS],
  output logic [RPM_W-1:0] mot_set   [NUM_MOTORS]
);

  localparam int               TGT_W   = RPM_W + 2;
  localparam logic [RPM_W-1:0] RPM_MAX = '1;

  altcmd_e                 alt_p0;
  dircmd_e                 dir_p0;
  logic [RPM_W-1:0]        sense_p0 [NUM_MOTORS];
  logic                    vld_p0;
  logic signed [TGT_W-1:0] base_p0;

  function automatic logic [RPM_W-1:0] sat_target(input logic signed [TGT_W-1:0] v);
    if (v[TGT_W-1]) return '0;
    else if (|v[TGT_W-2:RPM_W]) return RPM_MAX;
    else return v[RPM_W-1:0];
  endfunction

  // ---- stage boundary: input register ----
  // Capture commands and sensed RPMs; vld_p0 holds off the first update after reset.
  always_ff @(posedge clk) begin
    if (resetn) begin
      alt_p0 <= ALT_HOLD;
      dir_p0 <= DIR_NONE;
      vld_p0 <= 1'b0;
      for (int i = 0; i < NUM_MOTORS; i++) sense_p0[i] <= '0;
    end else begin
      alt_p0 <= altcmd_e'(altcmd);
      dir_p0 <= dircmd_e'(dircmd);
      vld_p0 <= 1'b1;
      for (int i = 0; i < NUM_MOTORS; i++) sense_p0[i] <= rpm_sense[i];
    end
  end

  // Altitude base target shared by all motors (LAND is forced per motor).
  always_comb begin
    case (alt_p0)
      ALT_CLIMB:   base_p0 = TGT_W'(HOVER_RPM + ALT_DELTA);
      ALT_DESCEND: base_p0 = TGT_W'(HOVER_RPM - ALT_DELTA);
      default:     base_p0 = TGT_W'(HOVER_RPM);
    endcase
  end

  for (genvar m = 0; m < NUM_MOTORS; m++) begin : g_motor
    logic signed [TGT_W-1:0] off_p0;
    logic [RPM_W-1:0]        tgt_p0;

    // Direction offset for this motor and its saturated target.
    always_comb begin
      case (dir_sign(dir_p0, 2'(m)))
        SGN_POS: off_p0 = TGT_W'(DIR_DELTA);
        SGN_NEG: off_p0 = -TGT_W'(DIR_DELTA);
        default: off_p0 = '0;
      endcase
      tgt_p0 = (alt_p0 == ALT_LAND) ? '0 : sat_target(base_p0 + off_p0);
    end

    motor_ctrl #(
      .RPM_W     (RPM_W),
      .GAIN_SHIFT(GAIN_SHIFT),
      .MAX_SLEW  (MAX_SLEW)
    ) u_motor (
      .clk    (clk),
      .rst    (resetn),
      .en     (vld_p0),
      .target (tgt_p0),
      .sense  (sense_p0[m]),
      .mot_set(mot_set[m])
    );
  end

endmodule

// File: tb/tb_drone_top.sv
// tb_drone_top: drives a default drone_top and a HOVER_RPM=240 copy with the
// same commands, compares every cycle against a behavioural model, and runs
// a vector table plus hand-written reset, convergence, saturation and
// latency sequences.
module tb_drone_top;

`ifdef DRONE_TOP_SLEW_LIMIT_EN
  localparam int SLEW = 8;
`else
  localparam int SLEW = 1000;
`endif

  logic       clk = 1'b0;
  logic       resetn;
  logic [1:0] altcmd;
  logic [2:0] dircmd;
  logic [7:0] sense_def [4];
  logic [7:0] sense_hi  [4];
  logic [7:0] set_def   [4];
  logic [7:0] set_hi    [4];

  always #5 clk = ~clk;

  drone_top dut (
    .clk(clk), .resetn(resetn), .altcmd(altcmd), .dircmd(dircmd),
    .rpm_sense(sense_def), .mot_set(set_def)
  );

  drone_top #(.HOVER_RPM(240)) dut_hi (
    .clk(clk), .resetn(resetn), .altcmd(altcmd), .dircmd(dircmd),
    .rpm_sense(sense_hi), .mot_set(set_hi)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  int mdl_def [4];
  int mdl_hi  [4];
  bit echo_def = 1'b0;
  bit echo_hi  = 1'b0;

  typedef struct packed {
    logic [1:0]      alt;
    logic [2:0]      dir;
    logic [3:0][7:0] sdef;
    logic [3:0][7:0] shi;
  } snap_t;
  snap_t hist[$];

  typedef struct packed {
    logic [1:0]      alt;
    logic [2:0]      dir;
    logic [3:0][7:0] tgt;
  } vec_t;
  vec_t vecs [9];

  function automatic int clamp8(input int v);
    if (v < 0) return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  function automatic int ref_target(input int hover, input int alt, input int dir, input int m);
    int base;
    int sgn;
    if (alt == 3) return 0;
    base = hover + ((alt == 1) ? 32 : (alt == 2) ? -32 : 0);
    case (dir)
      1: sgn = (m == 2 || m == 3) ? 1 : -1;
      2: sgn = (m == 0 || m == 1) ? 1 : -1;
      3: sgn = (m == 1 || m == 2) ? 1 : -1;
      4: sgn = (m == 0 || m == 3) ? 1 : -1;
      5: sgn = (m == 1 || m == 3) ? 1 : -1;
      6: sgn = (m == 0 || m == 2) ? 1 : -1;
      default: sgn = 0;
    endcase
    return clamp8(base + 16 * sgn);
  endfunction

  function automatic int ref_step(input int cur, input int tgt, input int sense);
    int e;
    int d;
    e = tgt - sense;
    d = e >>> 2;
    if (e != 0 && d == 0) d = (e > 0) ? 1 : -1;
    if (d > SLEW) d = SLEW;
    if (d < -SLEW) d = -SLEW;
    return clamp8(cur + d);
  endfunction

  function automatic int first_step(input int tgt);
    int d;
    d = tgt / 4;
    if (d == 0 && tgt != 0) d = 1;
    if (d > SLEW) d = SLEW;
    return d;
  endfunction

  task automatic check(input string name, input int idx, input logic [7:0] got, input int exp);
    n_checks++;
    if (got !== 8'(exp)) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, got, exp);
    end
  endtask

  // One clock: advance the model at the edge, compare both DUTs after it.
  task automatic tick();
    snap_t s;
    snap_t p;
    s.alt = altcmd;
    s.dir = dircmd;
    for (int i = 0; i < 4; i++) begin
      s.sdef[i] = sense_def[i];
      s.shi[i]  = sense_hi[i];
    end
    @(posedge clk);
    if (resetn) begin
      for (int i = 0; i < 4; i++) begin
        mdl_def[i] = 0;
        mdl_hi[i]  = 0;
      end
      hist.delete();
    end else begin
      if (hist.size() != 0) begin
        p = hist.pop_front();
        for (int i = 0; i < 4; i++) begin
          mdl_def[i] = ref_step(mdl_def[i], ref_target(128, int'(p.alt), int'(p.dir), i), int'(p.sdef[i]));
          mdl_hi[i]  = ref_step(mdl_hi[i],  ref_target(240, int'(p.alt), int'(p.dir), i), int'(p.shi[i]));
        end
      end
      hist.push_back(s);
    end
    #1;
    for (int i = 0; i < 4; i++) begin
      check("model_def", i, set_def[i], mdl_def[i]);
      check("model_hi", i, set_hi[i], mdl_hi[i]);
    end
    for (int i = 0; i < 4; i++) begin
      if (echo_def) sense_def[i] = 8'(mdl_def[i]);
      if (echo_hi)  sense_hi[i]  = 8'(mdl_hi[i]);
    end
  endtask

  task automatic set_senses(input int v);
    for (int i = 0; i < 4; i++) begin
      sense_def[i] = 8'(v);
      sense_hi[i]  = 8'(v);
    end
  endtask

  // Echo loop near its target: each motor must touch it and stay within one count.
  task automatic settle_window(input string name, input int t0, input int t1, input int t2, input int t3);
    int tg [4];
    bit hit [4];
    int worst [4];
    int d;
    tg = '{t0, t1, t2, t3};
    for (int i = 0; i < 4; i++) begin
      hit[i]   = 1'b0;
      worst[i] = 0;
    end
    repeat (8) begin
      tick();
      for (int i = 0; i < 4; i++) begin
        d = int'(set_def[i]) - tg[i];
        if (d < 0) d = -d;
        if (d == 0) hit[i] = 1'b1;
        if (d > worst[i]) worst[i] = d;
      end
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (!hit[i] || worst[i] > 1) begin
        n_fail++;
        $display("FAIL %s[%0d]: got deviation %0d reached %0d, expected deviation <=1 reached 1",
                 name, i, worst[i], hit[i]);
      end
    end
  endtask

  initial begin
    int base [4];
    int off [4];

    vecs[0] = '{alt: 2'd0, dir: 3'd0, tgt: {8'd128, 8'd128, 8'd128, 8'd128}};
    vecs[1] = '{alt: 2'd1, dir: 3'd1, tgt: {8'd176, 8'd176, 8'd144, 8'd144}};
    vecs[2] = '{alt: 2'd2, dir: 3'd2, tgt: {8'd80,  8'd80,  8'd112, 8'd112}};
    vecs[3] = '{alt: 2'd0, dir: 3'd3, tgt: {8'd112, 8'd144, 8'd144, 8'd112}};
    vecs[4] = '{alt: 2'd1, dir: 3'd4, tgt: {8'd176, 8'd144, 8'd144, 8'd176}};
    vecs[5] = '{alt: 2'd2, dir: 3'd5, tgt: {8'd112, 8'd80,  8'd112, 8'd80}};
    vecs[6] = '{alt: 2'd0, dir: 3'd6, tgt: {8'd112, 8'd144, 8'd112, 8'd144}};
    vecs[7] = '{alt: 2'd3, dir: 3'd1, tgt: {8'd0,   8'd0,   8'd0,   8'd0}};
    vecs[8] = '{alt: 2'd1, dir: 3'd7, tgt: {8'd160, 8'd160, 8'd160, 8'd160}};

    // Reset held two cycles with arbitrary inputs
    resetn = 1'b1;
    altcmd = 2'($urandom_range(0, 3));
    dircmd = 3'($urandom_range(0, 7));
    for (int i = 0; i < 4; i++) begin
      sense_def[i] = 8'($urandom_range(0, 255));
      sense_hi[i]  = 8'($urandom_range(0, 255));
    end
    tick();
    tick();
    for (int i = 0; i < 4; i++) check("reset", i, set_def[i], 0);

    // Release into HOLD/NONE with sense 0: first move on the second edge
    resetn = 1'b0;
    altcmd = 2'd0;
    dircmd = 3'd0;
    set_senses(0);
    tick();
    for (int i = 0; i < 4; i++) check("first_edge", i, set_def[i], 0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      for (int i = 0; i < 4; i++) check("hold_ramp", i, set_def[i], k * ((SLEW < 32) ? SLEW : 32));
    end

    // Table: one and two updates from reset with sense 0
    for (int v = 0; v < 9; v++) begin
      resetn = 1'b1;
      altcmd = vecs[v].alt;
      dircmd = vecs[v].dir;
      set_senses(0);
      tick();
      resetn = 1'b0;
      tick();
      tick();
      for (int i = 0; i < 4; i++) check("table_1st", v * 4 + i, set_def[i], first_step(int'(vecs[v].tgt[i])));
      tick();
      for (int i = 0; i < 4; i++) check("table_2nd", v * 4 + i, set_def[i], 2 * first_step(int'(vecs[v].tgt[i])));
    end

    // CLIMB/FWD echo loop
    resetn = 1'b1;
    tick();
    resetn = 1'b0;
    altcmd = 2'd1;
    dircmd = 3'd1;
    set_senses(0);
    echo_def = 1'b1;
    echo_hi  = 1'b1;
    repeat (100) tick();
    settle_window("climb_fwd", 144, 144, 176, 176);

    // HOLD settle, then YAW_CW, then LAND with an arbitrary direction
    altcmd = 2'd0;
    dircmd = 3'd0;
    repeat (100) tick();
    settle_window("hold", 128, 128, 128, 128);
    dircmd = 3'd5;
    repeat (100) tick();
    settle_window("yaw_cw", 112, 144, 112, 144);
    altcmd = 2'd3;
    dircmd = 3'($urandom_range(0, 7));
    repeat (60) tick();
    for (int i = 0; i < 4; i++) check("land", i, set_def[i], 0);

    // High hover: CLIMB/BACK saturates all targets at 255
    resetn = 1'b1;
    tick();
    resetn = 1'b0;
    altcmd = 2'd1;
    dircmd = 3'd2;
    set_senses(0);
    repeat (80) tick();
    for (int i = 0; i < 4; i++) check("sat_top", i, set_hi[i], 255);

    // Sense pinned at 255 with LAND: large negative steps floor at 0
    echo_def = 1'b0;
    for (int i = 0; i < 4; i++) sense_def[i] = 8'd255;
    altcmd = 2'd3;
    repeat (30) tick();
    for (int i = 0; i < 4; i++) check("sat_floor", i, set_def[i], 0);

    // Latency: single-cycle LEFT pulse from a static HOLD point
    altcmd = 2'd0;
    dircmd = 3'd0;
    for (int i = 0; i < 4; i++) sense_def[i] = 8'd0;
    repeat (3) tick();
    for (int i = 0; i < 4; i++) sense_def[i] = 8'd128;
    repeat (3) tick();
    for (int i = 0; i < 4; i++) base[i] = mdl_def[i];
    off = '{-4, 4, 4, -4};
    dircmd = 3'd3;
    tick();
    dircmd = 3'd0;
    for (int i = 0; i < 4; i++) check("lat_edge1", i, set_def[i], base[i]);
    tick();
    for (int i = 0; i < 4; i++) check("lat_edge2", i, set_def[i], base[i] + off[i]);
    tick();
    for (int i = 0; i < 4; i++) check("lat_edge3", i, set_def[i], base[i] + off[i]);

    // Randomized traffic against the model
    repeat (400) begin
      resetn = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 7) == 0) begin
        altcmd = 2'($urandom_range(0, 3));
        dircmd = 3'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 15) == 0) begin
        echo_def = 1'($urandom_range(0, 1));
        echo_hi  = 1'($urandom_range(0, 1));
      end
      for (int i = 0; i < 4; i++) begin
        if (!echo_def) sense_def[i] = 8'($urandom_range(0, 255));
        if (!echo_hi)  sense_hi[i]  = 8'($urandom_range(0, 255));
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
